prime_generator: RTL and testbench

PRIME_GENERATOR -- requirements
Module: prime_generator

---
 rtl/prime_generator.sv | 119 +++++++++++
 tb/tb_prime_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prime_generator.sv
// prime_generator: trial-division sweep of all primes in [2, 2^W-1], emitted over a valid/ready handshake.
// Optional macro PRIME_GEN_INDEX_EN adds an 'index' output carrying the ordinal of the current prime.
module prime_generator #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ready,
  output logic [W-1:0] prime,
`ifdef PRIME_GEN_INDEX_EN
  output logic [W-1:0] index,
`endif
  output logic         valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MOD    = 3'd2,
    CHECK  = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [W-1:0] TWO = {{(W-2){1'b0}}, 2'b10};

  state_t         state;
  logic [W-1:0]   n;
  logic [W-1:0]   d;
  logic [W-1:0]   r;
  logic [2*W-1:0] dsq;
  logic [2*W-1:0] nwide;
  logic           last_cand;

  // Square is formed at full 2W width so d*d > n never wraps.
  always_comb begin
    dsq       = {{W{1'b0}}, d} * {{W{1'b0}}, d};
    nwide     = {{W{1'b0}}, n};
    last_cand = (n == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n     <= '0;
      d     <= '0;
      r     <= '0;
      prime <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n     <= TWO;
            state <= LOAD;
          end
        end
        LOAD: begin
          d     <= TWO;
          r     <= n;
          state <= MOD;
        end
        MOD: begin
          if (r >= d) r <= r - d;
          else        state <= CHECK;
        end
        CHECK: begin
          if ((r == '0) && (d < n)) begin
            if (last_cand) state <= FINISH;
            else begin
              n     <= n + 1'b1;
              state <= LOAD;
            end
          end else if ((dsq > nwide) || (d == n)) begin
            prime <= n;
            state <= EMIT;
          end else begin
            d     <= d + 1'b1;
            r     <= n;
            state <= MOD;
          end
        end
        EMIT: begin
          if (ready) begin
            if (last_cand) state <= FINISH;
            else begin
              n     <= n + 1'b1;
              state <= LOAD;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRIME_GEN_INDEX_EN
  logic [W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        idx <= '0;
    else if ((state == IDLE) && start) idx <= '0;
    else if ((state == EMIT) && ready) idx <= idx + 1'b1;
  end

  always_comb index = idx;
`endif

  // Status outputs decode registered state, so reset clears them immediately and glitch-free.
  always_comb begin
    valid = (state == EMIT);
    busy  = (state != IDLE);
    done  = (state == FINISH);
  end

endmodule

// File: tb/tb_prime_generator.sv
// tb_prime_generator: checks W=3 and W=8 sweeps against a trial-division prime list, with random
// ready backpressure, a forced stall on 13, ignored start pulses and an asynchronous reset mid-handshake.
module tb_prime_generator;

  logic       clk;
  logic       rst_n;
  logic       start3, ready3, valid3, busy3, done3;
  logic [2:0] prime3;
  logic       start8, ready8, valid8, busy8, done8;
  logic [7:0] prime8;
`ifdef PRIME_GEN_INDEX_EN
  logic [2:0] index3;
  logic [7:0] index8;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp3[$];
  int exp8[$];

  prime_generator #(.W(3)) u_w3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start3),
    .ready (ready3),
    .prime (prime3),
`ifdef PRIME_GEN_INDEX_EN
    .index (index3),
`endif
    .valid (valid3),
    .busy  (busy3),
    .done  (done3)
  );

  prime_generator #(.W(8)) u_w8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .ready (ready8),
    .prime (prime8),
`ifdef PRIME_GEN_INDEX_EN
    .index (index8),
`endif
    .valid (valid8),
    .busy  (busy8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int q = 2; q * q <= v; q++)
      if (v % q == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    int k;
    int stall;
    int dones;
    bit acc_last;

    for (int v = 2; v < 8; v++)   if (is_prime(v)) exp3.push_back(v);
    for (int v = 2; v < 256; v++) if (is_prime(v)) exp8.push_back(v);

    rst_n  = 1'b0;
    start3 = 1'b0; ready3 = 1'b0;
    start8 = 1'b0; ready8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid8", valid8, 0);
    check("rst_busy8",  busy8,  0);
    check("rst_done8",  done8,  0);
    check("rst_prime8", prime8, 0);
    check("rst_busy3",  busy3,  0);
    check("rst_prime3", prime3, 0);
`ifdef PRIME_GEN_INDEX_EN
    check("rst_index8", index8, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy8", busy8, 0);

    // W=3 sweep, ready tied high
    ready3 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("w3_busy_after_start", busy3, 1);
    k = 0; dones = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (valid3) begin
        if (k < exp3.size()) check("w3_prime", prime3, exp3[k]);
        else                 check("w3_extra_valid", valid3, 0);
`ifdef PRIME_GEN_INDEX_EN
        check("w3_index", index3, k);
`endif
        k++;
      end
      if (done3) begin
        dones++;
        break;
      end
    end
    check("w3_done_seen", dones, 1);
    check("w3_count", k, 4);
    @(negedge clk);
    check("w3_done_pulse", done3, 0);
    check("w3_busy_end", busy3, 0);
    check("w3_valid_end", valid3, 0);

    // W=8 full sweep with random ready, a 20-cycle stall on 13, and stray start pulses
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0; stall = 0; dones = 0; acc_last = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      if (acc_last) check("w8_gap", valid8, 0);
      acc_last = 1'b0;
      if (done8) begin
        dones++;
        break;
      end
      check("w8_busy", busy8, 1);
      if (valid8) begin
        if (k < exp8.size()) check("w8_prime", prime8, exp8[k]);
        else                 check("w8_extra_valid", valid8, 0);
`ifdef PRIME_GEN_INDEX_EN
        check("w8_index", index8, k);
        if (k < exp8.size() && exp8[k] == 101) check("w8_index_101", index8, 25);
        if (k < exp8.size() && exp8[k] == 251) check("w8_index_251", index8, 53);
`endif
        if (k < exp8.size() && exp8[k] == 13 && stall < 20) begin
          check("bp_hold13", prime8, 13);
          ready8 = 1'b0;
          stall++;
        end else begin
          ready8 = ($urandom_range(3) != 0);
        end
        if (ready8) begin
          k++;
          acc_last = 1'b1;
        end
      end else begin
        ready8 = 1'($urandom_range(1));
      end
      start8 = (k >= 5 && k <= 45 && $urandom_range(15) == 0);
    end
    start8 = 1'b0;
    check("w8_done_seen", dones, 1);
    check("w8_count", k, 54);
    check("bp_stall_cycles", stall, 20);
    @(negedge clk);
    check("w8_done_pulse", done8, 0);
    check("w8_busy_end", busy8, 0);

    // Reset while 31 is pending, then a fresh sweep must begin at 2
    ready8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (valid8) begin
        if (k < exp8.size()) check("r_prime", prime8, exp8[k]);
`ifdef PRIME_GEN_INDEX_EN
        check("r_index", index8, k);
`endif
        if (prime8 == 8'd31) begin
          ready8 = 1'b0;
          break;
        end
        k++;
      end
    end
    check("r_seen31", prime8, 31);
    @(negedge clk);
    check("r_hold_valid", valid8, 1);
    check("r_hold_prime", prime8, 31);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_valid", valid8, 0);
    check("r_async_busy",  busy8,  0);
    check("r_async_prime", prime8, 0);
    check("r_async_done",  done8,  0);
    @(negedge clk);
    rst_n  = 1'b1;
    ready8 = 1'b1;
    @(negedge clk);
    check("r_idle_busy", busy8, 0);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (valid8) begin
        dones = 1;
        break;
      end
    end
    check("r_restart_valid", dones, 1);
    check("r_restart_first", prime8, 2);
`ifdef PRIME_GEN_INDEX_EN
    check("r_restart_index", index8, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
